// File: rtl/addsub_seq_pkg.sv
// Shared types and sizing for the nibble-serial 16-bit adder/subtractor.
package addsub_seq_pkg;

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned NUM_NIB = 4;
    localparam int unsigned CNT_W   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operation captured on accept; ports are ignored afterwards.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             op;
    } req_t;

endpackage

// File: rtl/addsub4_slice.sv
// Combinational 4-bit ripple adder exposing every internal carry-out.
module addsub4_slice
    import addsub_seq_pkg::*;
(
    input  logic [NIB_W-1:0] x,
    input  logic [NIB_W-1:0] y,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic [NIB_W-1:0] c
);

    logic carry;

    // Ripple the carry bit by bit; c[i] is the carry out of bit i.
    always_comb begin
        sum   = '0;
        c     = '0;
        carry = cin;
        for (int i = 0; i < int'(NIB_W); i++) begin
            sum[i] = x[i] ^ y[i] ^ carry;
            carry  = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
            c[i]   = carry;
        end
    end

endmodule

// File: rtl/addsub16_seq.sv
// 16-bit add/subtract computed one nibble per cycle through a shared 4-bit slice.
module addsub16_seq
    import addsub_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    state_t           state;
    state_t           state_nx;
    req_t             req_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;

    logic [NIB_W-1:0] slice_x;
    logic [NIB_W-1:0] slice_y;
    logic [NIB_W-1:0] slice_sum;
    logic [NIB_W-1:0] slice_c;
    logic             last_nib;
    logic             accept;

    logic             in_ready_nx;
    logic             out_valid_nx;
    logic             busy_nx;

    assign accept   = (state == IDLE) && in_valid && in_ready;
    assign last_nib = (cnt_q == CNT_W'(NUM_NIB - 1));

    // Nibble select: {cnt_q, 2'b00} is cnt_q * NIB_W; b is inverted here for subtract.
    assign slice_x = req_q.a[{cnt_q, 2'b00} +: NIB_W];
    assign slice_y = req_q.b[{cnt_q, 2'b00} +: NIB_W] ^ {NIB_W{req_q.op}};

    addsub4_slice u_slice (
        .x   (slice_x),
        .y   (slice_y),
        .cin (carry_q),
        .sum (slice_sum),
        .c   (slice_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = RUN;
            RUN:     if (last_nib) state_nx = DONE;
            DONE:    if (out_valid && out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake/status values for the coming cycle, decoded from the next state.
    always_comb begin
        in_ready_nx  = 1'b0;
        out_valid_nx = 1'b0;
        busy_nx      = 1'b0;
        in_ready_nx  = (state_nx == IDLE);
        out_valid_nx = (state_nx == DONE);
        busy_nx      = (state_nx != IDLE);
    end

    // Registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            in_ready  <= in_ready_nx;
            out_valid <= out_valid_nx;
            busy      <= busy_nx;
        end
    end

    // Operand capture and one nibble of arithmetic per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            result  <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (accept) begin
            req_q   <= {a, b, op};
            carry_q <= op;
            cnt_q   <= '0;
        end else if (state == RUN) begin
            result[{cnt_q, 2'b00} +: NIB_W] <= slice_sum;
            carry_q <= slice_c[NIB_W-1];
            cnt_q   <= cnt_q + 1'b1;
            if (last_nib) begin
                cout <= slice_c[NIB_W-1];
                ovf  <= slice_c[NIB_W-2] ^ slice_c[NIB_W-1];
            end
        end
    end

endmodule

// File: tb/tb_addsub16_seq.sv
// Randomized self-checking bench for addsub16_seq with a cycle-level reference model.
module tb_addsub16_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        cout;
    logic        ovf;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    addsub16_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Reference arithmetic: plain integer add/subtract and signed range test.
    function automatic logic [17:0] model_calc(input logic [15:0] x, input logic [15:0] y,
                                               input logic o);
        int s;
        int sv;
        logic [15:0] r;
        logic c;
        logic v;
        s  = o ? (int'(x) + 65536 - int'(y)) : (int'(x) + int'(y));
        r  = 16'(s);
        c  = (s > 65535);
        sv = o ? (int'($signed(x)) - int'($signed(y))) : (int'($signed(x)) + int'($signed(y)));
        v  = (sv > 32767) || (sv < -32768);
        return {r, c, v};
    endfunction

    // Cycle model: 0 idle, 1 working, 2 result presented.
    int          m_mode  = 0;
    int          m_cyc   = 0;
    bit          m_live  = 0;
    bit          m_zero  = 0;
    logic [17:0] m_pend;
    logic [17:0] m_out;

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0;
            m_cyc  = 0;
            m_zero = 1;
            m_out  = '0;
            m_live = 1;
        end else if (m_live) begin
            case (m_mode)
                0: if (in_valid) begin
                    m_pend = model_calc(a, b, op);
                    m_mode = 1;
                    m_cyc  = 0;
                    m_zero = 0;
                end
                1: begin
                    m_cyc++;
                    if (m_cyc == 4) begin
                        m_mode = 2;
                        m_out  = m_pend;
                    end
                end
                default: if (out_ready) m_mode = 0;
            endcase
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            chk("in_ready",  32'(in_ready),  32'(m_mode == 0));
            chk("out_valid", 32'(out_valid), 32'(m_mode == 2));
            chk("busy",      32'(busy),      32'(m_mode != 0));
            if (m_mode == 2 || m_zero) begin
                chk("result", 32'(result), 32'(m_out[17:2]));
                chk("cout",   32'(cout),   32'(m_out[1]));
                chk("ovf",    32'(ovf),    32'(m_out[0]));
            end
        end
    end

    // Issue one request; optionally pulse junk requests during RUN/DONE; stall the consumer.
    task automatic run_op(input logic [15:0] xa, input logic [15:0] xb, input logic xo,
                          input int stall, input bit junk,
                          output logic [17:0] got, output int lat);
        @(negedge clk);
        in_valid = 1'b1; a = xa; b = xb; op = xo;
        lat = 0;
        got = 'x;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                in_valid = 1'b0;
                a = 16'($urandom); b = 16'($urandom); op = 1'($urandom);
            end
            if (lat == 2 && junk) in_valid = 1'b1;
            if (lat == 3) in_valid = 1'b0;
            if (out_valid) break;
        end
        if (!out_valid) begin
            chk("latency_timeout", 32'(lat), 32'd5);
            return;
        end
        got = {result, cout, ovf};
        in_valid = junk;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_hold", 32'({result, cout, ovf}), 32'(got));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    logic [15:0] ta [8];
    logic [15:0] tb_ [8];
    logic        to [8];
    logic [17:0] texp [8];
    logic [17:0] got;
    int          lat;

    initial begin
        ta[0] = 16'h1234; tb_[0] = 16'h0FFF; to[0] = 0; texp[0] = {16'h2233, 1'b0, 1'b0};
        ta[1] = 16'h7FFF; tb_[1] = 16'h0001; to[1] = 0; texp[1] = {16'h8000, 1'b0, 1'b1};
        ta[2] = 16'h0005; tb_[2] = 16'h0006; to[2] = 1; texp[2] = {16'hFFFF, 1'b0, 1'b0};
        ta[3] = 16'h8000; tb_[3] = 16'h0001; to[3] = 1; texp[3] = {16'h7FFF, 1'b1, 1'b1};
        ta[4] = 16'hFFFF; tb_[4] = 16'h0001; to[4] = 0; texp[4] = {16'h0000, 1'b1, 1'b0};
        ta[5] = 16'h0000; tb_[5] = 16'h0001; to[5] = 1; texp[5] = {16'hFFFF, 1'b0, 1'b0};
        ta[6] = 16'h8000; tb_[6] = 16'h8000; to[6] = 0; texp[6] = {16'h0000, 1'b1, 1'b1};
        ta[7] = 16'h4321; tb_[7] = 16'h4321; to[7] = 1; texp[7] = {16'h0000, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors: pin the model with literals, then the DUT and its latency.
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("model_pin%0d", i), 32'(model_calc(ta[i], tb_[i], to[i])), 32'(texp[i]));
            run_op(ta[i], tb_[i], to[i], (i == 0) ? 3 : (i % 3), (i == 0), got, lat);
            chk($sformatf("dir_result%0d", i), 32'(got), 32'(texp[i]));
            chk($sformatf("dir_latency%0d", i), 32'(lat), 32'd5);
        end

        // Reset during the second RUN cycle discards the operation.
        @(negedge clk);
        in_valid = 1'b1; a = 16'hABCD; b = 16'h1111; op = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result",    32'({result, cout, ovf}), 32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst_no_pulse", 32'(out_valid), 32'd0);
        run_op(16'h0001, 16'h0001, 1'b0, 0, 0, got, lat);
        chk("post_rst_result", 32'(got), 32'({16'h0002, 1'b0, 1'b0}));

        // Randomized traffic checked against the model.
        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic        ro;
            ra = 16'($urandom);
            rb = 16'($urandom);
            ro = 1'($urandom_range(0, 1));
            run_op(ra, rb, ro, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), got, lat);
            chk("rand_result", 32'(got), 32'(model_calc(ra, rb, ro)));
            chk("rand_latency", 32'(lat), 32'd5);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
